lcd_i2c_seq: RTL



---
 rtl/lcd_i2c_seq.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_i2c_seq.sv
// lcd_i2c_seq: command sequencer feeding an I2C master that drives an HD44780
// character LCD through a PCF8574 backpack in 4-bit mode.
//
// After reset it waits 50 ms and then plays the HD44780 4-bit init sequence.
// It then accepts command/data bytes. Every LCD byte or init nibble becomes one
// PCF8574 write transaction: one command beat on m_cmd_*, then 2 or 4 data
// bytes on m_data_*. After each transaction the sequencer waits for the master
// to go idle and then waits out the HD44780 execution time.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   char_tdata/rs/tvalid  LCD byte input (rs=1 display data, rs=0 instruction)
//   char_tready           high in IDLE once init is complete
//   init_done, error      sticky status flags (error = any missed_ack)
//   m_cmd_*               command interface to the I2C master
//   m_data_*              write-data stream to the I2C master
//   busy, missed_ack      status from the I2C master
module lcd_i2c_seq #(
  parameter logic [6:0] I2C_ADDR  = 7'h27,
  parameter int         CLK_HZ    = 12_000_000,
  parameter int         BACKLIGHT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_tdata,
  input  logic       char_rs,
  input  logic       char_tvalid,
  output logic       char_tready,
  output logic       init_done,
  output logic       error,
  output logic [6:0] m_cmd_address,
  output logic       m_cmd_start,
  output logic       m_cmd_read,
  output logic       m_cmd_write,
  output logic       m_cmd_write_multiple,
  output logic       m_cmd_stop,
  output logic       m_cmd_valid,
  input  logic       m_cmd_ready,
  output logic [7:0] m_data_tdata,
  output logic       m_data_tvalid,
  input  logic       m_data_tready,
  output logic       m_data_tlast,
  input  logic       busy,
  input  logic       missed_ack
);

  localparam int          T_US     = CLK_HZ / 1_000_000;
  localparam logic [23:0] POR_LOAD = 24'(50_000 * T_US - 1);
  localparam logic        BL       = (BACKLIGHT != 0);

  typedef enum logic [2:0] {
    S_POR_WAIT, S_LOAD, S_CMD, S_DATA, S_WAIT_BUSY, S_DELAY, S_IDLE
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;            // delay down-counter
  logic [23:0] dly_q, dly_d;            // post-delay of current transaction, in cycles
  logic [7:0]  byte_q, byte_d;          // byte being sent; init nibbles sit in [7:4]
  logic        rs_q, rs_d;
  logic        four_q, four_d;          // 1 = full byte (4 PCF bytes), 0 = nibble (2)
  logic [1:0]  idx_q, idx_d;            // PCF byte index within the transaction
  logic [2:0]  init_idx_q, init_idx_d;
  logic        init_done_q, init_done_d;
  logic        error_q, error_d;

  function automatic logic [23:0] us_to_cycles(input int us);
    return 24'(us * T_US);
  endfunction

  // Init ROM
  logic [7:0] rom_value;
  logic       rom_is_byte;
  int         rom_us;

  always_comb begin
    rom_value   = 8'h00;
    rom_is_byte = 1'b0;
    rom_us      = 40;
    case (init_idx_q)
      3'd0: begin rom_value = 8'h30; rom_us = 4_100; end
      3'd1: begin rom_value = 8'h30; rom_us = 100;   end
      3'd2: begin rom_value = 8'h30; rom_us = 100;   end
      3'd3: begin rom_value = 8'h20; rom_us = 100;   end
      3'd4: begin rom_value = 8'h28; rom_is_byte = 1'b1; end
      3'd5: begin rom_value = 8'h0C; rom_is_byte = 1'b1; end
      3'd6: begin rom_value = 8'h01; rom_is_byte = 1'b1; rom_us = 2_000; end
      default: begin rom_value = 8'h06; rom_is_byte = 1'b1; end
    endcase
  end

  // Clear display / return home need the long execution time.
  logic long_cmd;
  assign long_cmd = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);

  logic last_byte;
  assign last_byte = (idx_q == (four_q ? 2'd3 : 2'd1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_POR_WAIT;
      cnt_q       <= POR_LOAD;
      dly_q       <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      four_q      <= 1'b0;
      idx_q       <= '0;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dly_q       <= dly_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      four_q      <= four_d;
      idx_q       <= idx_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dly_d       = dly_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    four_d      = four_q;
    idx_d       = idx_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    error_d     = error_q | missed_ack;
    case (state_q)
      S_POR_WAIT: begin
        if (cnt_q == '0) state_d = S_LOAD;
        else             cnt_d   = cnt_q - 24'd1;
      end
      S_LOAD: begin
        if (!init_done_q) begin
          byte_d = rom_value;
          rs_d   = 1'b0;
          four_d = rom_is_byte;
          dly_d  = us_to_cycles(rom_us);
        end else begin
          dly_d  = us_to_cycles(long_cmd ? 2_000 : 40);
        end
        idx_d   = '0;
        state_d = S_CMD;
      end
      S_CMD: begin
        if (m_cmd_ready) state_d = S_DATA;
      end
      S_DATA: begin
        if (m_data_tready) begin
          if (last_byte) state_d = S_WAIT_BUSY;
          else           idx_d   = idx_q + 2'd1;
        end
      end
      S_WAIT_BUSY: begin
        if (!busy) begin
          cnt_d   = dly_q - 24'd1;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 24'd1;
        end else if (init_done_q) begin
          state_d = S_IDLE;
        end else if (init_idx_q == 3'd7) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          init_idx_d = init_idx_q + 3'd1;
          state_d    = S_LOAD;
        end
      end
      S_IDLE: begin
        if (char_tvalid && init_done_q) begin
          byte_d  = char_tdata;
          rs_d    = char_rs;
          four_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_POR_WAIT;
    endcase
  end

  // Outputs
  logic [3:0] nibble;

  always_comb begin
    // Even PCF bytes carry EN=1, odd bytes EN=0; the second pair of a full
    // byte carries the low nibble.
    nibble               = (four_q && idx_q[1]) ? byte_q[3:0] : byte_q[7:4];
    m_cmd_address        = I2C_ADDR;
    m_cmd_start          = 1'b0;
    m_cmd_read           = 1'b0;
    m_cmd_write          = 1'b0;
    m_cmd_valid          = (state_q == S_CMD);
    m_cmd_write_multiple = m_cmd_valid;
    m_cmd_stop           = m_cmd_valid;
    m_data_tvalid        = (state_q == S_DATA);
    m_data_tdata         = m_data_tvalid ? {nibble, BL, ~idx_q[0], 1'b0, rs_q} : 8'h00;
    m_data_tlast         = m_data_tvalid && last_byte;
    char_tready          = (state_q == S_IDLE) && init_done_q;
    init_done            = init_done_q;
    error                = error_q;
  end

endmodule
